// File: rtl/interposer_pkg.sv
// Shared constants and segment mask helpers for the 8-node interposer chain.
package interposer_pkg;

  localparam int NODE_COUNT = 8;
  localparam int DEST_W     = 3;
  localparam int LEN_W      = 4;
  localparam int LINK_COUNT = NODE_COUNT - 1;
  localparam int CTRL_W     = 3 * NODE_COUNT;

  // Bit positions inside each node's {tx, rx, bp} control triple
  localparam int CTRL_TX = 2;
  localparam int CTRL_RX = 1;
  localparam int CTRL_BP = 0;

  // A transfer is legal only when it moves downstream and lands on a real node
  function automatic logic dest_legal(input logic [DEST_W-1:0] src,
                                      input logic [DEST_W-1:0] dst);
    return (int'(dst) > int'(src)) && (int'(dst) < NODE_COUNT);
  endfunction

  // Links src..dst-1 are occupied by a src->dst transfer
  function automatic logic [LINK_COUNT-1:0] link_mask(input logic [DEST_W-1:0] src,
                                                      input logic [DEST_W-1:0] dst);
    logic [LINK_COUNT-1:0] m;
    m = '0;
    for (int k = 0; k < LINK_COUNT; k++) begin
      if (k >= int'(src) && k < int'(dst)) m[k] = 1'b1;
    end
    return m;
  endfunction

  // Source drives tx, destination rx, every node strictly between forwards (bp)
  function automatic logic [CTRL_W-1:0] ctrl_mask(input logic [DEST_W-1:0] src,
                                                  input logic [DEST_W-1:0] dst);
    logic [CTRL_W-1:0] m;
    m = '0;
    for (int n = 0; n < NODE_COUNT; n++) begin
      if (n == int'(src)) m[3*n + CTRL_TX] = 1'b1;
      if (n == int'(dst)) m[3*n + CTRL_RX] = 1'b1;
      if (n > int'(src) && n < int'(dst)) m[3*n + CTRL_BP] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/segment_picker.sv
// Rotating greedy scan: grants every candidate whose links are still free.
module segment_picker
  import interposer_pkg::*;
(
  input  logic [DEST_W-1:0]            ptr,
  input  logic [LINK_COUNT-1:0]        busy_links,
  input  logic [NODE_COUNT-1:0]        cand,
  input  logic [NODE_COUNT*DEST_W-1:0] req_dest,
  output logic [NODE_COUNT-1:0]        grant,
  output logic [DEST_W-1:0]            first_idx,
  output logic                         any_grant
);

  logic [LINK_COUNT-1:0] taken;
  logic [LINK_COUNT-1:0] m;
  logic [DEST_W-1:0]     src;
  logic [DEST_W-1:0]     dst;
  int                    idx;

  // Walk nodes from ptr, claiming links as grants are made so later nodes see them
  always_comb begin
    grant     = '0;
    any_grant = 1'b0;
    first_idx = ptr;
    taken     = busy_links;
    idx       = 0;
    src       = '0;
    dst       = '0;
    m         = '0;
    for (int j = 0; j < NODE_COUNT; j++) begin
      idx = (int'(ptr) + j) % NODE_COUNT;
      src = DEST_W'(idx);
      dst = req_dest[idx*DEST_W +: DEST_W];
      m   = link_mask(src, dst);
      if (cand[idx] && ((m & taken) == '0)) begin
        grant[idx] = 1'b1;
        taken      = taken | m;
        if (!any_grant) begin
          any_grant = 1'b1;
          first_idx = src;
        end
      end
    end
  end

endmodule

// File: rtl/segment_transfer_scheduler.sv
// Multi-cycle burst scheduler: one slot per source node, links released in the last flit.
module segment_transfer_scheduler
  import interposer_pkg::*;
(
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         hold,
  input  logic [NODE_COUNT-1:0]        req_valid,
  input  logic [NODE_COUNT*DEST_W-1:0] req_dest,
  input  logic [NODE_COUNT*LEN_W-1:0]  req_len,
  output logic [NODE_COUNT-1:0]        req_ready,
  output logic [NODE_COUNT-1:0]        req_err,
  output logic [CTRL_W-1:0]            control_port,
  output logic                         busy
);

  logic [NODE_COUNT-1:0] active_q;
  logic [NODE_COUNT-1:0] active_nx;
  logic [DEST_W-1:0]     dest_q  [NODE_COUNT];
  logic [DEST_W-1:0]     dest_nx [NODE_COUNT];
  logic [LEN_W-1:0]      cnt_q   [NODE_COUNT];
  logic [LEN_W-1:0]      cnt_nx  [NODE_COUNT];
  logic [DEST_W-1:0]     ptr_q;
  logic [DEST_W-1:0]     ptr_nx;

  logic [NODE_COUNT-1:0] illegal;
  logic [NODE_COUNT-1:0] cand;
  logic [NODE_COUNT-1:0] grant;
  logic [LINK_COUNT-1:0] busy_links;
  logic [CTRL_W-1:0]     ctrl_nx;
  logic [DEST_W-1:0]     first_idx;
  logic                  any_grant;

  // Classify requests and collect links held by slots that are not in their last flit
  always_comb begin
    illegal    = '0;
    cand       = '0;
    busy_links = '0;
    for (int i = 0; i < NODE_COUNT; i++) begin
      if (req_valid[i]) begin
        if (dest_legal(DEST_W'(i), req_dest[i*DEST_W +: DEST_W])) begin
          cand[i] = !hold && (!active_q[i] || (cnt_q[i] == '0));
        end else begin
          illegal[i] = 1'b1;
        end
      end
      if (active_q[i] && (cnt_q[i] != '0)) begin
        busy_links = busy_links | link_mask(DEST_W'(i), dest_q[i]);
      end
    end
  end

  segment_picker u_picker (
    .ptr        (ptr_q),
    .busy_links (busy_links),
    .cand       (cand),
    .req_dest   (req_dest),
    .grant      (grant),
    .first_idx  (first_idx),
    .any_grant  (any_grant)
  );

  // Handshake is held off while reset is asserted so nothing is consumed then
  assign req_ready = reset ? '0 : (grant | illegal);
  assign req_err   = reset ? '0 : illegal;

  // Slot update: a grant overrides the expiring burst; control follows next-cycle slots
  always_comb begin
    active_nx = active_q;
    ctrl_nx   = '0;
    ptr_nx    = ptr_q;
    for (int i = 0; i < NODE_COUNT; i++) begin
      dest_nx[i] = dest_q[i];
      cnt_nx[i]  = cnt_q[i];
      if (grant[i]) begin
        active_nx[i] = 1'b1;
        dest_nx[i]   = req_dest[i*DEST_W +: DEST_W];
        cnt_nx[i]    = req_len[i*LEN_W +: LEN_W];
      end else if (active_q[i]) begin
        if (cnt_q[i] != '0) begin
          cnt_nx[i] = cnt_q[i] - LEN_W'(1);
        end else begin
          active_nx[i] = 1'b0;
        end
      end
      if (active_nx[i]) begin
        ctrl_nx = ctrl_nx | ctrl_mask(DEST_W'(i), dest_nx[i]);
      end
    end
    if (any_grant) begin
      ptr_nx = (int'(first_idx) == NODE_COUNT - 1) ? '0 : first_idx + DEST_W'(1);
    end
  end

  // State register; reset discards any in-flight bursts
  always_ff @(posedge clk) begin
    if (reset) begin
      active_q     <= '0;
      ptr_q        <= '0;
      control_port <= '0;
      busy         <= 1'b0;
      for (int i = 0; i < NODE_COUNT; i++) begin
        dest_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
    end else begin
      active_q     <= active_nx;
      ptr_q        <= ptr_nx;
      control_port <= ctrl_nx;
      busy         <= |active_nx;
      dest_q       <= dest_nx;
      cnt_q        <= cnt_nx;
    end
  end

endmodule
